// File: rtl/fifo_8x32_pkg.sv
// Shared definitions for the 8 x 32 FIFO: sizes, state encoding, pointer helper.
package fifo_8x32_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int DEPTH       = 8;
    localparam int ADDR_WIDTH  = 3;
    localparam int COUNT_WIDTH = 4;

    localparam logic [COUNT_WIDTH-1:0] COUNT_FULL = COUNT_WIDTH'(DEPTH);

    // Operation performed on the edge that entered the state; flags decode from it.
    typedef enum logic [2:0] {
        ST_INIT     = 3'b000,
        ST_NO_OP    = 3'b001,
        ST_WRITE    = 3'b010,
        ST_WR_ERROR = 3'b011,
        ST_READ     = 3'b100,
        ST_RD_ERROR = 3'b101
    } state_e;

    // Pointers are exactly log2(DEPTH) bits, so the natural overflow gives the 7->0 wrap.
    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] ptr);
        return ptr + 1'b1;
    endfunction

endpackage

// File: rtl/fifo_reg8x32.sv
// 8 x 32 register file: resettable word registers, one write port, one combinational read port.
module fifo_reg8x32
    import fifo_8x32_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] entry_w [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [DATA_WIDTH-1:0] word_q;
            logic                  sel_w;

            assign sel_w = we && (wr_addr == ADDR_WIDTH'(gi));

            // Each entry loads only when addressed; the reset clears stored data.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    word_q <= '0;
                end else if (sel_w) begin
                    word_q <= wr_data;
                end
            end

            assign entry_w[gi] = word_q;
        end
    endgenerate

    assign rd_data = entry_w[rd_addr];

endmodule

// File: rtl/fifo_8x32.sv
// Synchronous 8-entry x 32-bit FIFO with per-operation ack/error flags and occupancy count.
module fifo_8x32
    import fifo_8x32_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [DATA_WIDTH-1:0]  d_in,
    output logic [DATA_WIDTH-1:0]  d_out,
    output logic                   full,
    output logic                   empty,
    output logic                   wr_ack,
    output logic                   wr_err,
    output logic                   rd_ack,
    output logic                   rd_err,
    output logic [COUNT_WIDTH-1:0] data_count
);

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  head_q, head_d;
    logic [ADDR_WIDTH-1:0]  tail_q, tail_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [DATA_WIDTH-1:0]  dout_q, dout_d;
    logic [DATA_WIDTH-1:0]  rd_data_w;
    logic                   we_w;

    assign full  = (count_q == COUNT_FULL);
    assign empty = (count_q == '0);

    // Next state: a lone request picks its operation or its error; both or neither is a no-op.
    always_comb begin
        state_d = ST_NO_OP;
        if (wr_en && !rd_en) begin
            state_d = full ? ST_WR_ERROR : ST_WRITE;
        end else if (rd_en && !wr_en) begin
            state_d = empty ? ST_RD_ERROR : ST_READ;
        end
    end

    // Datapath acts on the edge that enters WRITE/READ, so it follows state_d, not state_q.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        dout_d  = dout_q;
        we_w    = 1'b0;
        if (state_d == ST_WRITE) begin
            we_w    = 1'b1;
            tail_d  = ptr_inc(tail_q);
            count_d = count_q + 1'b1;
        end else if (state_d == ST_READ) begin
            dout_d  = rd_data_w;
            head_d  = ptr_inc(head_q);
            count_d = count_q - 1'b1;
        end
    end

    // State, pointers, occupancy and output word registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_INIT;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            dout_q  <= dout_d;
        end
    end

    fifo_reg8x32 u_regfile (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (we_w),
        .wr_addr (tail_q),
        .wr_data (d_in),
        .rd_addr (head_q),
        .rd_data (rd_data_w)
    );

    assign d_out      = dout_q;
    assign data_count = count_q;
    assign wr_ack     = (state_q == ST_WRITE);
    assign wr_err     = (state_q == ST_WR_ERROR);
    assign rd_ack     = (state_q == ST_READ);
    assign rd_err     = (state_q == ST_RD_ERROR);

endmodule
